// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM states, settle window and key-map helpers for the keypad debouncer
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } idx_t;
    localparam int SETTLE_CYCLES = 3;
    // Nibble {row, col} of this constant holds the hex code printed on that key
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
    endfunction
    function automatic idx_t onehot_idx(input logic [3:0] v);
        idx_t r;
        r.valid = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
        r.idx   = lowest_idx(v);
        return r;
    endfunction
    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];
    endfunction
endpackage

// File: rtl/keypad_debounce_sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs, cleared to 0 on reset
module sync2 #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end
    assign o_q = r_s2;
endmodule

// File: rtl/keypad_debounce.sv
// keypad_debounce: paces the row scanner, debounces key press/release, emits hex key codes
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_row,
    input  logic [3:0] i_col,
    output logic       o_scan_en,
    output logic       o_press,
    output logic [3:0] o_key,
    output logic       o_key_valid
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SETTLE   = SW'(SETTLE_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    logic [3:0]    w_col_s;
    idx_t          w_row;
    logic [1:0]    w_col_idx;
    logic          w_det;
    logic          w_bit;
    logic          w_capture;
    logic          w_accept;
    state_t        r_state;
    state_t        w_state_n;
    logic [SW-1:0] r_scnt;
    logic [SW-1:0] w_scnt_n;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_n;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_pend;
    logic [3:0]    r_key;
    logic          r_key_valid;
    logic          r_press;
    logic          r_scan_en;
    sync2 #(.W(4)) u_col_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_col),
        .o_q     (w_col_s)
    );
    assign w_row     = onehot_idx(i_row);
    assign w_col_idx = lowest_idx(w_col_s);
    assign w_bit     = w_col_s[r_col_idx];
    // The first few cycles after a row step are skipped so a stale column from the previous row cannot match
    assign w_det     = w_row.valid && (r_scnt >= SETTLE) && (w_col_s != 4'd0);
    always_comb begin
        w_state_n = r_state;
        w_scnt_n  = '0;
        w_dcnt_n  = r_dcnt;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                w_scnt_n = (r_scnt == SCAN_MAX) ? '0 : r_scnt + 1'b1;
                if (w_det) begin
                    w_state_n = DEBOUNCE;
                    w_scnt_n  = '0;
                    w_dcnt_n  = '0;
                    w_capture = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!w_bit) w_state_n = IDLE;
                else if (r_dcnt == DEB_MAX) begin
                    w_state_n = HELD;
                    w_accept  = 1'b1;
                end else w_dcnt_n = r_dcnt + 1'b1;
            end
            HELD: begin
                if (!w_bit) begin
                    w_state_n = RELEASE;
                    w_dcnt_n  = '0;
                end
            end
            RELEASE: begin
                if (w_bit) w_state_n = HELD;
                else if (r_dcnt == DEB_MAX) w_state_n = IDLE;
                else w_dcnt_n = r_dcnt + 1'b1;
            end
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_scnt      <= '0;
            r_dcnt      <= '0;
            r_col_idx   <= '0;
            r_pend      <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_press     <= 1'b0;
            r_scan_en   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_scnt      <= w_scnt_n;
            r_dcnt      <= w_dcnt_n;
            r_press     <= (w_state_n != IDLE);
            r_scan_en   <= (w_state_n == IDLE) && (w_scnt_n == SCAN_MAX);
            r_key_valid <= w_accept;
            if (w_accept) r_key <= r_pend;
            if (w_capture) begin
                r_col_idx <= w_col_idx;
                r_pend    <= key_lookup(w_row.idx, w_col_idx);
            end
        end
    end
    assign o_scan_en   = r_scan_en;
    assign o_press     = r_press;
    assign o_key       = r_key;
    assign o_key_valid = r_key_valid;
endmodule
